regfile_debug_scanner: RTL
==========================

// Module: regfile_debug_scanner
// PURPOSE
//   Reader side of the register-file debug port. Walks register addresses 0..NUM_REGS-1
//   on read_address_debug and samples data_out_debug once the read has settled.
//   Formats each register as 12 ASCII chars "Rdd:hhhhhhhh" and streams them with
//   valid/ready to the VGA text-buffer writer. Used in the VGA demo for live register display.
// PARAMETERS
//   NUM_REGS      32   registers scanned per frame (max 32; index shown as 2 decimal digits)
//   ROWS_PER_COL  16   screen rows per display column; reg i -> row i%ROWS_PER_COL
//   COL_STRIDE    14   char columns between display columns; base col = (i/ROWS_PER_COL)*COL_STRIDE
//   READ_WAIT     1    clocks from address drive to data sample (regfile latches on negedge)
//   REFRESH_GAP   1024 idle clocks between frames in continuous mode
// PORTS
//   clock              in   1   system clock; all state on posedge
//   reset_n            in   1   asynchronous, active-low reset
//   scan_start         in   1   1-cycle pulse: begin one frame when idle
//   scan_continuous    in   1   1 = auto-restart frames REFRESH_GAP clocks after frame_done
//   scan_busy          out  1   1 from frame start until last char accepted
//   frame_done         out  1   1-cycle pulse after last char of last register accepted
//   read_address_debug out  5   register address to regfile debug port (clock_debug tied to clock)
//   data_out_debug     in   32  register value returned by regfile debug port
//   char_valid         out  1   char payload valid
//   char_ready         in   1   text buffer accepts char
//   char_code          out  8   ASCII code
//   char_col           out  7   screen column 0..79
//   char_row           out  5   screen row 0..29
//   char_attr          out  1   highlight attribute (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async assert, sync release): state IDLE, all outputs 0, reg index 0, gap counter 0.
//   FSM: IDLE -> ADDR -> WAIT -> CAPTURE -> EMIT -> (next reg: ADDR | last reg: DONE) -> IDLE.
//   IDLE: leaves on scan_start, or on scan_continuous when gap counter == REFRESH_GAP-1.
//     scan_start while busy ignored; scan_continuous deasserted mid-frame finishes current frame.
//   ADDR: drive read_address_debug = idx (held stable through CAPTURE). WAIT: READ_WAIT clocks.
//   CAPTURE: latch data_out_debug into 32-bit value register; char counter = 0.
//   EMIT: char k (0..11): 'R', tens, ones, ':', nibbles [31:28] down to [3:0] as '0'-'9','A'-'F'.
//     char_col = base col + k; char_row = idx % ROWS_PER_COL.
//   Handshake: transfer at posedge with char_valid && char_ready. While valid && !ready all
//     payload held stable. After transfer next char presented following cycle (1 char/clk max).
//     char_valid never deasserted without transfer except by reset.
//   DONE: frame_done pulses 1 cycle, scan_busy drops same cycle, gap counter cleared.
//   Reset mid-frame: valid drops immediately; next frame restarts at register 0.
//   Frame length with char_ready=1: NUM_REGS*(2+READ_WAIT+12)+1 clocks.
// CONFIGURATION
//   REGSCAN_HIGHLIGHT_EN defined: shadow array NUM_REGS x 32 plus per-reg seen bits
//     (cleared at reset). At CAPTURE, changed = seen[idx] && value != shadow[idx];
//     shadow[idx] updated, seen[idx] set. char_attr = changed for all 12 chars of that register.
//   Not defined: no shadow storage; char_attr constant 0. Port list identical either way.
// STRUCTURE
//   Package regscan_pkg: FSM state encodings, CHARS_PER_REG=12, ASCII constants
//     (CH_R=8'h52, CH_COLON=8'h3A, CH_ZERO=8'h30, CH_A=8'h41), screen limits 80x30.
//   Sub-module hex_to_ascii: combinational 4-bit nibble -> 8-bit ASCII, shared by
//     hex-digit and decimal-digit paths.
// TESTING
//   Bench regfile model: reg i = i, reg 29 = 32'h000000FC, negedge read, 1-cycle latency.
//   1 Reset: reset_n=0 mid-cycle -> all outputs 0 immediately, no char_valid until scan_start.
//   2 scan_start, ready=1 -> 384 chars; reg 29 gives "R29:000000FC" row 13 cols 14..25;
//     reg 0 gives "R00:00000000" row 0 cols 0..11; frame_done once, after 481 clocks.
//   3 ready low 5 clocks while reg 7 nibble char pending -> char_code/col/row stable, no loss.
//   4 reset_n pulse during EMIT of reg 10 -> valid drops; next scan_start restarts at "R00".
//   5 scan_continuous=1, REFRESH_GAP=16 -> frame_done pulses spaced 481+16 clocks; scan_start ignored when busy.
//   6 REGSCAN_HIGHLIGHT_EN: reg 5 set 32'hDEADBEEF between frames -> frame 1 attr all 0;
//     frame 2 attr=1 only on 12 chars of R05 ("R05:DEADBEEF"); frame 3 attr all 0.

Source files
------------

// File: rtl/regscan_pkg.sv
// rtl/regscan_pkg.sv - shared types and constants for the register-file debug scanner
package regscan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_EMIT    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam int CHARS_PER_REG = 12;

    localparam logic [7:0] CH_R     = 8'h52;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_A     = 8'h41;

    localparam int SCREEN_COLS = 80;
    localparam int SCREEN_ROWS = 30;

endpackage

// File: rtl/hex_to_ascii.sv
// rtl/hex_to_ascii.sv - combinational nibble to ASCII hex digit
module hex_to_ascii
    import regscan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = (nibble < 4'd10) ? (CH_ZERO + {4'd0, nibble})
                                    : (CH_A + {4'd0, nibble} - 8'd10);

endmodule

// File: rtl/regfile_debug_scanner.sv
// rtl/regfile_debug_scanner.sv - scans regfile debug port and streams "Rdd:hhhhhhhh" text
// Optional change highlighting is built when REGSCAN_HIGHLIGHT_EN is defined.
module regfile_debug_scanner
    import regscan_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int ROWS_PER_COL = 16,
    parameter int COL_STRIDE   = 14,
    parameter int READ_WAIT    = 1,
    parameter int REFRESH_GAP  = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        scan_start,
    input  logic        scan_continuous,
    output logic        scan_busy,
    output logic        frame_done,
    output logic [4:0]  read_address_debug,
    input  logic [31:0] data_out_debug,
    output logic        char_valid,
    input  logic        char_ready,
    output logic [7:0]  char_code,
    output logic [6:0]  char_col,
    output logic [4:0]  char_row,
    output logic        char_attr
);

    localparam logic [4:0]  LAST_REG  = 5'(NUM_REGS - 1);
    localparam logic [15:0] WAIT_LAST = 16'(READ_WAIT - 1);
    localparam logic [15:0] GAP_LAST  = 16'(REFRESH_GAP - 1);
    localparam logic [3:0]  LAST_CHAR = 4'(CHARS_PER_REG - 1);

    state_t      state, state_next;
    logic [4:0]  idx;
    logic [15:0] wait_cnt;
    logic [15:0] gap_cnt;
    logic [3:0]  char_cnt;
    logic [31:0] value;
    logic        changed;
    logic        xfer;
    logic        start_frame;
    logic [3:0]  tens, ones;
    logic [3:0]  nibble_sel;
    logic [7:0]  digit_ascii;
    logic [31:0] value_shifted;
    logic [6:0]  col_calc;
    logic [4:0]  row_calc;

    assign xfer        = (state == ST_EMIT) && char_ready;
    assign start_frame = (state == ST_IDLE) &&
                         (scan_start || (scan_continuous && gap_cnt == GAP_LAST));
    assign read_address_debug = idx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start_frame) state_next = ST_ADDR;
            ST_ADDR:    state_next = ST_WAIT;
            ST_WAIT:    if (wait_cnt == WAIT_LAST) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_EMIT;
            ST_EMIT:    if (xfer && char_cnt == LAST_CHAR)
                            state_next = (idx == LAST_REG) ? ST_DONE : ST_ADDR;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= '0;
            wait_cnt <= '0;
            gap_cnt  <= '0;
            char_cnt <= '0;
            value    <= '0;
        end else begin
            case (state)
                ST_IDLE:    gap_cnt <= (start_frame || !scan_continuous) ? 16'd0 : gap_cnt + 16'd1;
                ST_ADDR:    wait_cnt <= '0;
                ST_WAIT:    wait_cnt <= wait_cnt + 16'd1;
                ST_CAPTURE: begin
                    value    <= data_out_debug;
                    char_cnt <= '0;
                end
                ST_EMIT: begin
                    if (xfer) begin
                        char_cnt <= char_cnt + 4'd1;
                        if (char_cnt == LAST_CHAR)
                            idx <= (idx == LAST_REG) ? 5'd0 : idx + 5'd1;
                    end
                end
                ST_DONE:    gap_cnt <= '0;
                default:    ;
            endcase
        end
    end

`ifdef REGSCAN_HIGHLIGHT_EN
    logic [31:0]         shadow [NUM_REGS];
    logic [NUM_REGS-1:0] seen;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seen    <= '0;
            changed <= 1'b0;
        end else if (state == ST_CAPTURE) begin
            changed   <= seen[idx] && (data_out_debug != shadow[idx]);
            seen[idx] <= 1'b1;
        end
    end

    // Shadow contents are only meaningful once the matching seen bit is set.
    always_ff @(posedge clock) begin
        if (state == ST_CAPTURE) shadow[idx] <= data_out_debug;
    end
`else
    assign changed = 1'b0;
`endif

    always_comb begin
        tens = 4'd0;
        ones = idx[3:0];
        if (idx >= 5'd30) begin
            tens = 4'd3;
            ones = 4'(idx - 5'd30);
        end else if (idx >= 5'd20) begin
            tens = 4'd2;
            ones = 4'(idx - 5'd20);
        end else if (idx >= 5'd10) begin
            tens = 4'd1;
            ones = 4'(idx - 5'd10);
        end
    end

    // Char 4 shows bits [31:28], char 11 shows bits [3:0].
    assign value_shifted = value >> {4'(LAST_CHAR - char_cnt), 2'b00};

    always_comb begin
        case (char_cnt)
            4'd1:    nibble_sel = tens;
            4'd2:    nibble_sel = ones;
            default: nibble_sel = value_shifted[3:0];
        endcase
    end

    hex_to_ascii u_hex (
        .nibble (nibble_sel),
        .ascii  (digit_ascii)
    );

    assign col_calc = 7'((int'(idx) / ROWS_PER_COL) * COL_STRIDE) + 7'(char_cnt);
    assign row_calc = 5'(int'(idx) % ROWS_PER_COL);

    always_comb begin
        scan_busy  = 1'b0;
        frame_done = 1'b0;
        char_valid = 1'b0;
        char_code  = '0;
        char_col   = '0;
        char_row   = '0;
        char_attr  = 1'b0;
        case (state)
            ST_ADDR, ST_WAIT, ST_CAPTURE: scan_busy = 1'b1;
            ST_EMIT: begin
                scan_busy  = 1'b1;
                char_valid = 1'b1;
                char_code  = (char_cnt == 4'd0) ? CH_R :
                             (char_cnt == 4'd3) ? CH_COLON : digit_ascii;
                char_col   = col_calc;
                char_row   = row_calc;
                char_attr  = changed;
            end
            ST_DONE: frame_done = 1'b1;
            default: ;
        endcase
    end

endmodule
